complex_fu_seq_ctrl: RTL

//  Sequencing wrapper and result collector for the combinational complex (mult/div) ALU.
//  - Accepts one issued mult/div/syscall packet via valid/ready.
//  - Holds the operands stable on the ALU input ports for the opcode's modelled latency.
//  - Captures the ALU result and flags, then offers them to writeback on a valid/ready port.
//  - Sits between the complex-FU issue lane and the writeback/bypass stage; one op in flight.

---
 rtl/complex_fu_seq_ctrl_pkg.sv | 48 ++++
 rtl/complex_fu_seq_ctrl_if.sv | 43 ++++
 rtl/cfu_latency_decode.sv | 32 +++
 rtl/complex_fu_seq_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/complex_fu_seq_ctrl_pkg.sv
// Shared types and constants for the complex (mult/div) functional-unit sequencer.
package complex_fu_seq_ctrl_pkg;

  localparam int unsigned SIZE_OPCODE_I   = 6;
  localparam int unsigned EXECUTION_FLAGS = 4;
  localparam int unsigned FLAG_EXECUTED   = 0;
  localparam int unsigned FLAG_EXCEPTION  = 1;

  localparam int unsigned CFU_MUL_LAT = 3;
  localparam int unsigned CFU_DIV_LAT = 8;

  typedef logic [SIZE_OPCODE_I-1:0]   opcode_t;
  typedef logic [EXECUTION_FLAGS-1:0] flags_t;

  localparam opcode_t OP_SYSCALL = 6'h0C;
  localparam opcode_t OP_MULT_L  = 6'h20;
  localparam opcode_t OP_MULT_H  = 6'h21;
  localparam opcode_t OP_MULTU_L = 6'h22;
  localparam opcode_t OP_MULTU_H = 6'h23;
  localparam opcode_t OP_DIV_L   = 6'h24;
  localparam opcode_t OP_DIV_H   = 6'h25;
  localparam opcode_t OP_DIVU_L  = 6'h26;
  localparam opcode_t OP_DIVU_H  = 6'h27;

  typedef enum logic [1:0] {
    CFU_IDLE = 2'd0,
    CFU_EXEC = 2'd1,
    CFU_DONE = 2'd2
  } cfu_state_e;

  function automatic int unsigned cfu_max(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter must hold the largest latency value itself, hence the extra bit.
  function automatic int unsigned cfu_cnt_width(int unsigned mul_lat, int unsigned div_lat);
    return $clog2(cfu_max(mul_lat, div_lat)) + 1;
  endfunction

  function automatic flags_t div_zero_flags();
    flags_t f;
    f = '0;
    f[FLAG_EXECUTED]  = 1'b1;
    f[FLAG_EXCEPTION] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/complex_fu_seq_ctrl_if.sv
// Issue, ALU-operand and writeback bus of the complex-FU sequencer.
interface complex_fu_seq_ctrl_if #(
  parameter int unsigned SIZE_DATA = 32,
  parameter int unsigned SIZE_TAG  = 7
);
  import complex_fu_seq_ctrl_pkg::*;

  logic                   flush_i;
  logic                   issue_valid_i;
  logic                   issue_ready_o;
  opcode_t                opcode_i;
  logic [SIZE_DATA-1:0]   data1_i;
  logic [SIZE_DATA-1:0]   data2_i;
  logic [SIZE_TAG-1:0]    tag_i;

  opcode_t                alu_opcode_o;
  logic [SIZE_DATA-1:0]   alu_data1_o;
  logic [SIZE_DATA-1:0]   alu_data2_o;
  logic [2*SIZE_DATA-1:0] alu_result_i;
  flags_t                 alu_flags_i;

  logic                   wb_valid_o;
  logic                   wb_ready_i;
  logic [SIZE_TAG-1:0]    wb_tag_o;
  logic [SIZE_DATA-1:0]   wb_result_o;
  flags_t                 wb_flags_o;
  logic                   busy_o;

  modport slave (
    input  flush_i, issue_valid_i, opcode_i, data1_i, data2_i, tag_i,
    input  alu_result_i, alu_flags_i, wb_ready_i,
    output issue_ready_o, alu_opcode_o, alu_data1_o, alu_data2_o,
    output wb_valid_o, wb_tag_o, wb_result_o, wb_flags_o, busy_o
  );

  modport master (
    output flush_i, issue_valid_i, opcode_i, data1_i, data2_i, tag_i,
    output alu_result_i, alu_flags_i, wb_ready_i,
    input  issue_ready_o, alu_opcode_o, alu_data1_o, alu_data2_o,
    input  wb_valid_o, wb_tag_o, wb_result_o, wb_flags_o, busy_o
  );

endinterface

// File: rtl/cfu_latency_decode.sv
// Combinational opcode decode: divide class and modelled latency in cycles.
module cfu_latency_decode
  import complex_fu_seq_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = CFU_MUL_LAT,
  parameter int unsigned DIV_LAT = CFU_DIV_LAT,
  parameter int unsigned CNT_W   = cfu_cnt_width(CFU_MUL_LAT, CFU_DIV_LAT)
) (
  input  opcode_t          opcode_i,
  output logic             is_div_o,
  output logic [CNT_W-1:0] latency_o
);

  always_comb begin
    is_div_o  = 1'b0;
    latency_o = CNT_W'(1);
    case (opcode_i)
      OP_MULT_L, OP_MULT_H, OP_MULTU_L, OP_MULTU_H: begin
        latency_o = CNT_W'(MUL_LAT);
      end
      OP_DIV_L, OP_DIV_H, OP_DIVU_L, OP_DIVU_H: begin
        is_div_o  = 1'b1;
        latency_o = CNT_W'(DIV_LAT);
      end
      default: begin
        // SYSCALL and unrecognised opcodes complete in a single cycle.
        latency_o = CNT_W'(1);
      end
    endcase
  end

endmodule

// File: rtl/complex_fu_seq_ctrl.sv
// Sequencer around the combinational mult/div ALU: holds operands for the op's latency,
// captures the result and offers it to writeback. One operation in flight.
module complex_fu_seq_ctrl
  import complex_fu_seq_ctrl_pkg::*;
#(
  parameter int unsigned SIZE_DATA = 32,
  parameter int unsigned SIZE_TAG  = 7,
  parameter int unsigned MUL_LAT   = CFU_MUL_LAT,
  parameter int unsigned DIV_LAT   = CFU_DIV_LAT
) (
  input logic                  clk,
  input logic                  reset_n,
  complex_fu_seq_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = cfu_cnt_width(MUL_LAT, DIV_LAT);

  cfu_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 dec_is_div;
  logic [CNT_W-1:0]     dec_lat;

  opcode_t              alu_opcode_q;
  logic [SIZE_DATA-1:0] alu_data1_q;
  logic [SIZE_DATA-1:0] alu_data2_q;
  logic [SIZE_TAG-1:0]  tag_q;
  logic                 is_div_q;
  logic [SIZE_DATA-1:0] result_q;
  flags_t               flags_q;

  logic                 in_idle, in_exec, in_done;
  logic                 ready_int;
  logic                 accept;
  logic                 capture;
  logic                 div_by_zero;
  logic                 unused_result_hi;

  cfu_latency_decode #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_lat_dec (
    .opcode_i  (bus.opcode_i),
    .is_div_o  (dec_is_div),
    .latency_o (dec_lat)
  );

  assign in_idle   = (state_q == CFU_IDLE);
  assign in_exec   = (state_q == CFU_EXEC);
  assign in_done   = (state_q == CFU_DONE);
  assign ready_int = in_idle | (in_done & bus.wb_ready_i);

  // Flush wins over a same-cycle issue, so the accept itself is suppressed.
  assign accept      = bus.issue_valid_i & ready_int & ~bus.flush_i;
  assign capture     = in_exec & (cnt_q == CNT_W'(1)) & ~bus.flush_i;
  assign div_by_zero = is_div_q & (alu_data2_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CFU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CFU_IDLE: begin
        if (accept) begin
          state_d = CFU_EXEC;
          cnt_d   = dec_lat;
        end
      end
      CFU_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = CFU_DONE;
        end
      end
      CFU_DONE: begin
        // Retiring the result and accepting the next op share one cycle: no bubble.
        if (accept) begin
          state_d = CFU_EXEC;
          cnt_d   = dec_lat;
        end else if (bus.wb_ready_i) begin
          state_d = CFU_IDLE;
        end
      end
      default: begin
        state_d = CFU_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (bus.flush_i) begin
      state_d = CFU_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_opcode_q <= '0;
      alu_data1_q  <= '0;
      alu_data2_q  <= '0;
      tag_q        <= '0;
      is_div_q     <= 1'b0;
    end else if (accept) begin
      alu_opcode_q <= bus.opcode_i;
      alu_data1_q  <= bus.data1_i;
      alu_data2_q  <= bus.data2_i;
      tag_q        <= bus.tag_i;
      is_div_q     <= dec_is_div;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (capture) begin
      if (div_by_zero) begin
        result_q <= '0;
        flags_q  <= div_zero_flags();
      end else begin
        result_q <= bus.alu_result_i[SIZE_DATA-1:0];
        flags_q  <= bus.alu_flags_i;
      end
    end
  end

  assign unused_result_hi = ^bus.alu_result_i[2*SIZE_DATA-1:SIZE_DATA];

  // Qualified by reset_n so every output reads 0 while reset is held.
  assign bus.issue_ready_o = reset_n & ready_int;
  assign bus.busy_o        = ~in_idle;
  assign bus.wb_valid_o    = in_done;
  assign bus.wb_tag_o      = tag_q;
  assign bus.wb_result_o   = result_q;
  assign bus.wb_flags_o    = flags_q;
  assign bus.alu_opcode_o  = alu_opcode_q;
  assign bus.alu_data1_o   = alu_data1_q;
  assign bus.alu_data2_o   = alu_data2_q;

endmodule
